// File: rtl/kmeans_host.sv
// Host-side driver for the k-means engine: streams an LFSR-generated input frame,
// then collects the engine's 4-word centroid burst and reports completion status.
module kmeans_host #(
    parameter int          CLUSTER_SIZE = 4,
    parameter int          DATA_SIZE    = 4096,
    parameter logic [23:0] TIMEOUT      = 24'd8_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        km_in_valid,
    output logic [15:0] km_in_data,
    input  logic        km_out_valid,
    input  logic [15:0] km_out_data,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        err_burst,
    output logic [15:0] cent0,
    output logic [15:0] cent1,
    output logic [15:0] cent2,
    output logic [15:0] cent3
);

    localparam int                WORDS     = CLUSTER_SIZE + DATA_SIZE;
    localparam int                WCNT_W    = $clog2(WORDS);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS - 1);
    localparam logic [15:0]       SEED_ALT  = 16'hACE1;
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [1:0]        rcnt_q, rcnt_d;
    logic [23:0]       tcnt_q, tcnt_d;
    logic              in_valid_q, in_valid_d;
    logic [15:0]       in_data_q, in_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_burst_q, err_burst_d;
    logic [15:0]       cent_q [4];
    logic [15:0]       cent_d [4];
    logic [15:0]       lfsr_next;

    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        wcnt_d        = wcnt_q;
        rcnt_d        = rcnt_q;
        tcnt_d        = tcnt_q;
        in_valid_d    = 1'b0;
        in_data_d     = 16'h0000;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        err_timeout_d = err_timeout_q;
        err_burst_d   = err_burst_q;
        cent_d        = cent_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_d        = (seed == 16'h0000) ? SEED_ALT : seed;
                    wcnt_d        = '0;
                    rcnt_d        = '0;
                    tcnt_d        = '0;
                    err_timeout_d = 1'b0;
                    err_burst_d   = 1'b0;
                    cent_d        = '{default: 16'h0000};
                    state_d       = S_SEND;
                end
            end
            S_SEND: begin
                busy_d     = 1'b1;
                in_valid_d = 1'b1;
                in_data_d  = lfsr_q;
                lfsr_d     = lfsr_next;
                if (wcnt_q == WCNT_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (km_out_valid) begin
                    cent_d[0] = km_out_data;
                    rcnt_d    = 2'd1;
                    state_d   = S_RECV;
                end else if (tcnt_q == TIMEOUT - 24'd1) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_DONE;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 24'd1;
                end
            end
            S_RECV: begin
                busy_d = 1'b1;
                if (km_out_valid) begin
                    cent_d[rcnt_q] = km_out_data;
                    rcnt_d         = rcnt_q + 2'd1;
                    if (rcnt_q == 2'd3) begin
                        state_d = S_DONE;
                    end
                end else begin
                    // A short burst keeps whatever centroids already arrived.
                    err_burst_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the centroid array is reset too, since it drives outputs that must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lfsr_q        <= 16'h0000;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            tcnt_q        <= '0;
            in_valid_q    <= 1'b0;
            in_data_q     <= 16'h0000;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_burst_q   <= 1'b0;
            cent_q        <= '{default: 16'h0000};
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            tcnt_q        <= tcnt_d;
            in_valid_q    <= in_valid_d;
            in_data_q     <= in_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            err_burst_q   <= err_burst_d;
            cent_q        <= cent_d;
        end
    end

    assign km_in_valid = in_valid_q;
    assign km_in_data  = in_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign err_burst   = err_burst_q;
    assign cent0       = cent_q[0];
    assign cent1       = cent_q[1];
    assign cent2       = cent_q[2];
    assign cent3       = cent_q[3];

endmodule
